// File: rtl/io_pkg.sv
// Shared constants and helpers for the board input conditioner.
package io_pkg;

   localparam int BTN_W            = 5;
   localparam int DIP_W            = 24;
   localparam int TICK_DIV_DEF     = 50000;
   localparam int STABLE_TICKS_DEF = 8;

   typedef logic [BTN_W-1:0] btn_vec_t;
   typedef logic [DIP_W-1:0] dip_vec_t;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, tick-sampled debounce counter,
// debounced level and one-cycle rise/fall pulses aligned with the level update.
module debounce_bit
   import io_pkg::*;
#(
   parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int                CNT_W    = clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // NOTE: every flop here is assigned with <= so all bits see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            if (s2 == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level <= s2;
               cnt   <= '0;
               rise  <= s2;
               fall  <= ~s2;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces 5 buttons and 24 DIP switches behind a shared sample-tick prescaler.
// Optional button auto-repeat is compiled in with `define IO_INPUT_AUTOREPEAT_EN.
module io_input_conditioner
   import io_pkg::*;
#(
   parameter int TICK_DIV     = TICK_DIV_DEF,
   parameter int STABLE_TICKS = STABLE_TICKS_DEF
`ifdef IO_INPUT_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_W-1:0] io_btn,
   input  logic [DIP_W-1:0] io_dip,
   output logic [BTN_W-1:0] btn_level,
   output logic [BTN_W-1:0] btn_press,
   output logic [BTN_W-1:0] btn_release,
   output logic [DIP_W-1:0] dip_level,
   output logic             dip_change,
   output logic             tick
);

   localparam int               N        = BTN_W + DIP_W;
   localparam int               DIV_W    = clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [N-1:0]     raw_all;
   logic [N-1:0]     lvl_all;
   logic [N-1:0]     rise_all;
   logic [N-1:0]     fall_all;

   always_ff @(posedge clk) begin
      if (rst)                     div_cnt <= '0;
      else if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                         div_cnt <= div_cnt + DIV_W'(1);
   end

   assign tick    = (div_cnt == DIV_LAST);
   assign raw_all = {io_dip, io_btn};

   for (genvar i = 0; i < N; i++) begin : g_bit
      debounce_bit #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_bit (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .raw  (raw_all[i]),
         .level(lvl_all[i]),
         .rise (rise_all[i]),
         .fall (fall_all[i])
      );
   end

   assign btn_level   = lvl_all[BTN_W-1:0];
   assign btn_release = fall_all[BTN_W-1:0];
   assign dip_level   = lvl_all[N-1:BTN_W];
   assign dip_change  = |(rise_all[N-1:BTN_W] | fall_all[N-1:BTN_W]);

`ifdef IO_INPUT_AUTOREPEAT_EN
   localparam int               RPT_W      = clog2(REPEAT_DELAY + 1);
   localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

   logic [BTN_W-1:0][RPT_W-1:0] rpt_cnt;
   logic [BTN_W-1:0]            rpt_pulse;

   // The edge pulses mark the cycle right after a level change, which is never a tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_cnt   <= '0;
         rpt_pulse <= '0;
      end else begin
         for (int b = 0; b < BTN_W; b++) begin
            rpt_pulse[b] <= 1'b0;
            if (rise_all[b] || fall_all[b]) begin
               rpt_cnt[b] <= '0;
            end else if (tick && btn_level[b]) begin
               if (rpt_cnt[b] == RPT_LAST) begin
                  rpt_cnt[b]   <= RPT_RELOAD;
                  rpt_pulse[b] <= 1'b1;
               end else begin
                  rpt_cnt[b] <= rpt_cnt[b] + RPT_W'(1);
               end
            end
         end
      end
   end

   // A repeat landing on the releasing tick is masked by the now-low level.
   assign btn_press = rise_all[BTN_W-1:0] | (rpt_pulse & btn_level);
`else
   assign btn_press = rise_all[BTN_W-1:0];
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench: a tick-level reference model queues expected events,
// a negedge monitor pops and compares them and checks tick and levels every cycle.
module tb_io_input_conditioner;
   import io_pkg::*;

   localparam int TD = 4;
   localparam int ST = 3;
`ifdef IO_INPUT_AUTOREPEAT_EN
   localparam int RD = 5;
   localparam int RR = 2;
`endif
   localparam int N  = BTN_W + DIP_W;

   logic             clk = 1'b0;
   logic             rst;
   logic [BTN_W-1:0] io_btn;
   logic [DIP_W-1:0] io_dip;
   logic [BTN_W-1:0] btn_level, btn_press, btn_release;
   logic [DIP_W-1:0] dip_level;
   logic             dip_change, tick;

   always #5 clk = ~clk;

   io_input_conditioner #(
      .TICK_DIV    (TD),
      .STABLE_TICKS(ST)
`ifdef IO_INPUT_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .io_btn     (io_btn),
      .io_dip     (io_dip),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .dip_level  (dip_level),
      .dip_change (dip_change),
      .tick       (tick)
   );

   typedef struct {
      int               edge_no;
      logic [BTN_W-1:0] press;
      logic [BTN_W-1:0] rel;
      logic             dchg;
   } ev_t;

   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];

   // Reference model state
   int           edge_no = 0;
   bit           active  = 1'b0;
   int           cyc     = 0;
   logic [N-1:0] h1, h2, m_lvl;
   int           run[N];
   int           held[BTN_W];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_no);
      end
   endtask

   // Model: level follows the 2-cycle-delayed input after ST consecutive differing ticks.
   task automatic model_step();
      logic [N-1:0]     sync;
      logic [N-1:0]     pr_all, rl_all;
      logic [BTN_W-1:0] rose;
      logic             dc, tk;
      edge_no++;
      if (rst) begin
         active = 1'b1;
         cyc    = 0;
         h1     = '0;
         h2     = '0;
         m_lvl  = '0;
         for (int i = 0; i < N; i++) run[i] = 0;
         for (int b = 0; b < BTN_W; b++) held[b] = 0;
         return;
      end
      if (!active) return;
      tk   = ((cyc % TD) == TD - 1);
      cyc++;
      sync = h2;
      h2   = h1;
      h1   = {io_dip, io_btn};
      pr_all = '0;
      rl_all = '0;
      dc     = 1'b0;
      if (tk) begin
         for (int i = 0; i < N; i++) begin
            if (sync[i] != m_lvl[i]) begin
               run[i]++;
               if (run[i] == ST) begin
                  run[i]   = 0;
                  m_lvl[i] = sync[i];
                  if (i < BTN_W) begin
                     if (sync[i]) pr_all[i] = 1'b1;
                     else         rl_all[i] = 1'b1;
                  end else begin
                     dc = 1'b1;
                  end
               end
            end else begin
               run[i] = 0;
            end
         end
      end
      rose = pr_all[BTN_W-1:0];
`ifdef IO_INPUT_AUTOREPEAT_EN
      for (int b = 0; b < BTN_W; b++) begin
         if (rose[b]) begin
            held[b] = 0;
         end else if (tk && m_lvl[b]) begin
            held[b]++;
            if (held[b] >= RD && ((held[b] - RD) % RR) == 0) pr_all[b] = 1'b1;
         end
      end
`endif
      if ((|pr_all) || (|rl_all) || dc)
         exp_q.push_back('{edge_no, pr_all[BTN_W-1:0], rl_all[BTN_W-1:0], dc});
   endtask

   task automatic monitor_step();
      ev_t e;
      logic pulse;
      check("tick", {31'd0, tick}, {31'd0, ((cyc % TD) == TD - 1)});
      check("btn_level", {27'd0, btn_level}, {27'd0, m_lvl[BTN_W-1:0]});
      check("dip_level", {8'd0, dip_level}, {8'd0, m_lvl[N-1:BTN_W]});
      pulse = (|btn_press) || (|btn_release) || dip_change;
      if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_no) begin
         e = exp_q.pop_front();
         check("event_edge", edge_no, e.edge_no);
         check("btn_press", {27'd0, btn_press}, {27'd0, e.press});
         check("btn_release", {27'd0, btn_release}, {27'd0, e.rel});
         check("dip_change", {31'd0, dip_change}, {31'd0, e.dchg});
      end else if (pulse) begin
         check("unexpected_pulse", {20'd0, btn_press, btn_release, dip_change, 1'b0}, 32'd0);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (active) monitor_step();
      end
   end

   task automatic wait_ticks(input int n);
      repeat (n * TD) @(negedge clk);
   endtask

   initial begin
      io_btn = '0;
      io_dip = '0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_ticks(5);

      // Clean press and release on button 0
      io_btn[0] = 1'b1;
      wait_ticks(6);
      io_btn[0] = 1'b0;
      wait_ticks(6);

      // Glitch train on button 2: high 2 ticks, low 1 tick
      for (int r = 0; r < 5; r++) begin
         io_btn[2] = 1'b1;
         wait_ticks(2);
         io_btn[2] = 1'b0;
         wait_ticks(1);
      end
      wait_ticks(4);
      check("glitch_level", {31'd0, btn_level[2]}, 32'd0);

      // Whole DIP bank flips in one cycle
      io_dip = 24'hA5F00F;
      wait_ticks(6);
      check("dip_pattern", {8'd0, dip_level}, 32'h00A5F00F);

      // Reset while button 1 is part-way qualified
      io_btn[1] = 1'b1;
      wait_ticks(2);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_ticks(6);
      check("requalified", {31'd0, btn_level[1]}, 32'd1);
      io_btn[1] = 1'b0;
      wait_ticks(5);

      // Long hold on button 4 (repeats when auto-repeat is built in)
      io_btn[4] = 1'b1;
      wait_ticks(16);
      io_btn[4] = 1'b0;
      wait_ticks(6);

      // Randomized input activity with occasional resets
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) io_btn = BTN_W'($urandom);
         else                           io_btn[$urandom_range(0, BTN_W - 1)] ^= 1'b1;
         if ($urandom_range(0, 4) == 0) io_dip = io_dip ^ DIP_W'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         repeat ($urandom_range(1, 5 * TD)) @(negedge clk);
      end

      io_btn = '0;
      wait_ticks(ST + 4);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
